// File: rtl/secuenciador_correccion.sv
// Sequences one SECDED word through the external correction datapath; result valid LATENCIA+1 edges after inicio.
// Holds the result until dato_listo; inicio is dropped while busy; keeps saturating stats and a blinking double-error LED.
module secuenciador_correccion #(
   parameter int LATENCIA         = 2,
   parameter int ANCHO_CONT       = 8,
   parameter int PERIODO_PARPADEO = 13_500_000
) (
   input  logic                  reloj,
   input  logic                  rst_n,
   input  logic                  inicio,
   input  logic [7:0]            palabra_in,
   input  logic                  limpiar,
   output logic [7:0]            dp_palabra,
   input  logic                  dp_error_simple,
   input  logic                  dp_error_doble,
   input  logic [3:0]            dp_corregido,
   output logic                  ocupado,
   output logic                  dato_valido,
   input  logic                  dato_listo,
   output logic [3:0]            dato_out,
   output logic [1:0]            estado_error,
   output logic [ANCHO_CONT-1:0] cont_simple,
   output logic [ANCHO_CONT-1:0] cont_doble,
   output logic                  led_doblerror
);

   localparam int AW = $clog2(LATENCIA + 1);
   localparam int AP = (PERIODO_PARPADEO > 1) ? $clog2(PERIODO_PARPADEO) : 1;

   typedef enum logic [1:0] {
      REPOSO  = 2'd0,
      ESPERA  = 2'd1,
      ENTREGA = 2'd2
   } estado_t;

   estado_t        estado, estado_sig;
   logic [AW-1:0]  cont_esp;
   logic [AP-1:0]  cont_parpadeo;
   logic           parpadeo;
   logic           acepta, captura, fin;
   logic [1:0]     clase;

   always_ff @(posedge reloj or negedge rst_n) begin
      if (!rst_n) estado <= REPOSO;
      else        estado <= estado_sig;
   end

   // Capture one edge after the datapath's LATENCIA cycles have elapsed, so dp_* are settled.
   always_comb begin
      estado_sig = estado;
      acepta     = 1'b0;
      captura    = 1'b0;
      fin        = 1'b0;
      case (estado)
         REPOSO:  if (inicio) begin
                     acepta     = 1'b1;
                     estado_sig = ESPERA;
                  end
         ESPERA:  if (cont_esp == AW'(LATENCIA)) begin
                     captura    = 1'b1;
                     estado_sig = ENTREGA;
                  end
         ENTREGA: if (dato_listo) begin
                     fin        = 1'b1;
                     estado_sig = REPOSO;
                  end
         default: estado_sig = REPOSO;
      endcase
   end

   always_comb begin
      clase = 2'b00;
      if (dp_error_doble)       clase = 2'b10;
      else if (dp_error_simple) clase = 2'b01;
   end

   always_ff @(posedge reloj or negedge rst_n) begin
      if (!rst_n) begin
         dp_palabra   <= '0;
         ocupado      <= 1'b0;
         cont_esp     <= '0;
         dato_valido  <= 1'b0;
         dato_out     <= '0;
         estado_error <= 2'b00;
      end else begin
         if (acepta) begin
            dp_palabra <= palabra_in;
            ocupado    <= 1'b1;
            cont_esp   <= '0;
         end
         if (estado == ESPERA) cont_esp <= cont_esp + 1'b1;
         if (captura) begin
            dato_out     <= dp_corregido;
            estado_error <= clase;
            dato_valido  <= 1'b1;
         end
         if (fin) begin
            dato_valido <= 1'b0;
            ocupado     <= 1'b0;
         end
      end
   end

   // limpiar outranks the capture increment; counters stick at all-ones.
   always_ff @(posedge reloj or negedge rst_n) begin
      if (!rst_n) begin
         cont_simple <= '0;
         cont_doble  <= '0;
      end else if (limpiar) begin
         cont_simple <= '0;
         cont_doble  <= '0;
      end else if (captura) begin
         if (clase == 2'b01 && cont_simple != '1) cont_simple <= cont_simple + 1'b1;
         if (clase == 2'b10 && cont_doble  != '1) cont_doble  <= cont_doble + 1'b1;
      end
   end

   always_ff @(posedge reloj or negedge rst_n) begin
      if (!rst_n) begin
         led_doblerror <= 1'b0;
         cont_parpadeo <= '0;
         parpadeo      <= 1'b0;
      end else if (limpiar) begin
         led_doblerror <= 1'b0;
         cont_parpadeo <= '0;
         parpadeo      <= 1'b0;
      end else if (captura) begin
         led_doblerror <= (clase == 2'b10);
         cont_parpadeo <= '0;
         parpadeo      <= (clase == 2'b10);
      end else if (parpadeo) begin
         if (cont_parpadeo == AP'(PERIODO_PARPADEO - 1)) begin
            cont_parpadeo <= '0;
            led_doblerror <= ~led_doblerror;
         end else begin
            cont_parpadeo <= cont_parpadeo + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_secuenciador_correccion.sv
// Directed bench for secuenciador_correccion with a scoreboard of expected captures.
module tb_secuenciador_correccion;

   localparam int LAT = 2;
   localparam int AC  = 4;
   localparam int PP  = 4;
   localparam int MAXC = (1 << AC) - 1;

   logic          reloj = 1'b0;
   logic          rst_n, inicio, limpiar, dato_listo;
   logic          dp_error_simple, dp_error_doble;
   logic [7:0]    palabra_in, dp_palabra;
   logic [3:0]    dp_corregido, dato_out;
   logic          ocupado, dato_valido, led_doblerror;
   logic [1:0]    estado_error;
   logic [AC-1:0] cont_simple, cont_doble;

   typedef struct packed {
      logic [3:0] dato;
      logic [1:0] err;
   } res_t;

   res_t sb[$];
   res_t ult;
   int   checks = 0;
   int   failures = 0;
   int   exp_s = 0;
   int   exp_d = 0;

   secuenciador_correccion #(
      .LATENCIA(LAT), .ANCHO_CONT(AC), .PERIODO_PARPADEO(PP)
   ) dut (
      .reloj(reloj), .rst_n(rst_n), .inicio(inicio), .palabra_in(palabra_in),
      .limpiar(limpiar), .dp_palabra(dp_palabra),
      .dp_error_simple(dp_error_simple), .dp_error_doble(dp_error_doble),
      .dp_corregido(dp_corregido), .ocupado(ocupado), .dato_valido(dato_valido),
      .dato_listo(dato_listo), .dato_out(dato_out), .estado_error(estado_error),
      .cont_simple(cont_simple), .cont_doble(cont_doble), .led_doblerror(led_doblerror)
   );

   always #5 reloj = ~reloj;

   task automatic tick();
      @(posedge reloj);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Accept one word, wait for the capture and compare it with the scoreboard head.
   task automatic start(input logic [7:0] w, input logic s, input logic d,
                        input logic [3:0] c, input bit clr);
      res_t r;
      int   n;
      dp_error_simple = s;
      dp_error_doble  = d;
      dp_corregido    = c;
      palabra_in      = w;
      r.dato = c;
      r.err  = d ? 2'b10 : (s ? 2'b01 : 2'b00);
      sb.push_back(r);
      if (clr) begin
         exp_s = 0;
         exp_d = 0;
      end else if (r.err == 2'b01) begin
         exp_s = (exp_s < MAXC) ? exp_s + 1 : MAXC;
      end else if (r.err == 2'b10) begin
         exp_d = (exp_d < MAXC) ? exp_d + 1 : MAXC;
      end
      inicio = 1'b1;
      tick();
      inicio = 1'b0;
      chk("dp_palabra", dp_palabra, w);
      chk("ocupado_acepta", ocupado, 1);
      chk("valido_temprano", dato_valido, 0);
      n = 0;
      while (!dato_valido && n < 20) begin
         limpiar = clr && (n == LAT);
         tick();
         limpiar = 1'b0;
         n++;
      end
      chk("latencia", n, LAT + 1);
      chk("sb_tam", sb.size(), 1);
      if (sb.size() > 0) ult = sb.pop_front();
      chk("dato_out", dato_out, ult.dato);
      chk("estado_error", estado_error, ult.err);
      chk("cont_simple", cont_simple, exp_s);
      chk("cont_doble", cont_doble, exp_d);
      chk("dato_valido", dato_valido, 1);
   endtask

   // Hold ENTREGA for 'hold' cycles, then handshake; inicio optionally kept high throughout.
   task automatic finish(input int hold, input bit pulse);
      logic [7:0] dp0;
      dp0 = dp_palabra;
      palabra_in = 8'hFF;
      for (int i = 0; i < hold; i++) begin
         inicio = pulse;
         tick();
         chk("hold_valido", dato_valido, 1);
         chk("hold_dato", dato_out, ult.dato);
         chk("hold_err", estado_error, ult.err);
         chk("hold_ocupado", ocupado, 1);
      end
      inicio     = pulse;
      dato_listo = 1'b1;
      tick();
      dato_listo = 1'b0;
      inicio     = 1'b0;
      chk("hs_valido", dato_valido, 0);
      chk("hs_ocupado", ocupado, 0);
      chk("hs_dato_keep", dato_out, ult.dato);
      tick();
      tick();
      chk("post_ocupado", ocupado, 0);
      chk("post_dp_palabra", dp_palabra, dp0);
   endtask

   initial begin
      rst_n = 1'b0; inicio = 1'b0; limpiar = 1'b0; dato_listo = 1'b0;
      palabra_in = 8'h00; dp_error_simple = 1'b0; dp_error_doble = 1'b0; dp_corregido = 4'h0;
      #3;
      chk("rst_dp_palabra", dp_palabra, 0);
      chk("rst_ocupado", ocupado, 0);
      chk("rst_valido", dato_valido, 0);
      chk("rst_led", led_doblerror, 0);
      chk("rst_cont_simple", cont_simple, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Clean word
      start(8'hA5, 1'b0, 1'b0, 4'h9, 1'b0);
      chk("led_limpio", led_doblerror, 0);
      finish(0, 1'b0);

      // Single error, held result, ignored inicio
      start(8'h3C, 1'b1, 1'b0, 4'h6, 1'b0);
      finish(5, 1'b1);

      // Double error and LED blinking
      start(8'hC3, 1'b1, 1'b1, 4'h2, 1'b0);
      chk("led_on", led_doblerror, 1);
      repeat (3) tick();
      chk("led_antes_toggle", led_doblerror, 1);
      tick();
      chk("led_toggle1", led_doblerror, 0);
      repeat (4) tick();
      chk("led_toggle2", led_doblerror, 1);
      finish(0, 1'b0);
      start(8'h11, 1'b0, 1'b0, 4'h1, 1'b0);
      chk("led_apagado", led_doblerror, 0);
      finish(0, 1'b0);

      // Saturation
      for (int i = 0; i < 17; i++) begin
         start(8'(i), 1'b1, 1'b0, 4'(i), 1'b0);
         finish(0, 1'b0);
      end
      chk("saturado", cont_simple, 4'hF);

      // limpiar on the capture edge
      start(8'h77, 1'b1, 1'b0, 4'h5, 1'b1);
      chk("clr_doble", cont_doble, 0);
      finish(0, 1'b0);

      // Reset during ESPERA
      dp_error_simple = 1'b1; dp_error_doble = 1'b0; dp_corregido = 4'hE;
      palabra_in = 8'h42;
      inicio = 1'b1;
      tick();
      inicio = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("mrst_dp_palabra", dp_palabra, 0);
      chk("mrst_ocupado", ocupado, 0);
      chk("mrst_valido", dato_valido, 0);
      chk("mrst_dato_out", dato_out, 0);
      chk("mrst_err", estado_error, 0);
      chk("mrst_led", led_doblerror, 0);
      exp_s = 0;
      exp_d = 0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("mrst_sin_valido", dato_valido, 0);
      end
      start(8'h5A, 1'b0, 1'b1, 4'hB, 1'b0);
      chk("mrst_led_doble", led_doblerror, 1);
      finish(1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
